// File: rtl/counter_cmd_sequencer.sv
// Command sequencer ahead of the start/flag/wait-timer counter: queues commands, launches one run at a time.
// Start pulses two cycles after a push into an idle block; cmd_ready drops only while the FIFO is full.

// Generic synchronous FIFO, no bypass: data pushed at an edge is readable from the next cycle.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
endmodule

// Sequencer FSM: pop -> one-cycle start -> wait for busy ack -> wait for run end -> one low gap cycle.
// wait_timer/flag only change on a pop, so the counter sees them stable for the whole run.
module counter_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TW      = 5,
  parameter int ACK_TMO = 4,
  parameter int CW      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [TW-1:0]                cmd_wait,
  input  logic                         cmd_flag,
  input  logic                         cnt_busy,
  output logic                         start,
  output logic [TW-1:0]                wait_timer,
  output logic                         flag,
  output logic                         seq_busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CW-1:0]                issued_count,
  output logic                         err_timeout
);
  localparam int KW = $clog2(ACK_TMO + 1);

  typedef struct packed {
    logic [TW-1:0] wt;
    logic          flg;
  } cmd_t;

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_LAUNCH,
    SQ_ACK,
    SQ_RUN,
    SQ_GAP
  } sq_state_t;

  sq_state_t     state;
  sq_state_t     state_nxt;
  cmd_t          push_dat;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          run_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic [KW-1:0] ack_tmr;
  logic          ack_expired;

  assign push_dat = {cmd_wait, cmd_flag};
  assign push     = cmd_valid && cmd_ready;
  assign cmd_ready = !fifo_full;

  sync_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Timer holds the ack cycles still allowed; the last one is the cycle where it reads 1.
  assign ack_expired = (ack_tmr <= KW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= SQ_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SQ_IDLE:   if (!fifo_empty) state_nxt = SQ_LAUNCH;
      SQ_LAUNCH: state_nxt = SQ_ACK;
      SQ_ACK: begin
        if (cnt_busy)         state_nxt = SQ_RUN;
        else if (ack_expired) state_nxt = SQ_GAP;
      end
      SQ_RUN:    if (!cnt_busy) state_nxt = SQ_GAP;
      SQ_GAP:    state_nxt = SQ_IDLE;
      default:   state_nxt = SQ_IDLE;
    endcase
  end

  always_comb begin
    start       = 1'b0;
    pop         = 1'b0;
    run_done    = 1'b0;
    err_timeout = 1'b0;
    case (state)
      SQ_IDLE:   pop = !fifo_empty;
      SQ_LAUNCH: start = 1'b1;
      SQ_ACK:    err_timeout = !cnt_busy && ack_expired && !rst;
      SQ_RUN:    run_done = !cnt_busy;
      default:   ;
    endcase
  end

  assign seq_busy = (state != SQ_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_timer   <= '0;
      flag         <= 1'b0;
      ack_tmr      <= '0;
      issued_count <= '0;
    end else begin
      if (pop) begin
        wait_timer <= head.wt;
        flag       <= head.flg;
      end
      if (state == SQ_LAUNCH)
        ack_tmr <= KW'(ACK_TMO);
      else if (state == SQ_ACK && !cnt_busy)
        ack_tmr <= ack_tmr - 1'b1;
      if (run_done) issued_count <= issued_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: vector table for a single run, then hand sequences for
// timeout, backpressure, ordering, mid-run reset and completion-counter wrap.
module tb_counter_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TW      = 5;
  localparam int ACK_TMO = 4;
  localparam int CW      = 8;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int OW      = 5 + TW + LW + CW;
  localparam logic [OW-1:0] RST_OUT = 1;  // only cmd_ready (LSB) is high after reset

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] cmd_wait = '0;
  logic          cmd_flag = 1'b0;
  logic          cnt_busy = 1'b0;
  logic          start;
  logic [TW-1:0] wait_timer;
  logic          flag;
  logic          seq_busy;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] issued_count;
  logic          err_timeout;

  counter_cmd_sequencer #(
    .DEPTH(DEPTH), .TW(TW), .ACK_TMO(ACK_TMO), .CW(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wait     (cmd_wait),
    .cmd_flag     (cmd_flag),
    .cnt_busy     (cnt_busy),
    .start        (start),
    .wait_timer   (wait_timer),
    .flag         (flag),
    .seq_busy     (seq_busy),
    .fifo_level   (fifo_level),
    .issued_count (issued_count),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  logic man_busy  = 1'b0;
  logic auto_mode = 1'b0;
  int   cnt_left  = 0;
  int   n_starts  = 0;
  int   n_b2b     = 0;
  int   n_err     = 0;
  logic prev_start = 1'b0;
  logic [TW-1:0] st_q[$];

  typedef struct {
    logic v; logic [TW-1:0] w; logic f; logic b;
    logic st; logic [TW-1:0] wt; logic fl; logic sb;
    logic [LW-1:0] lvl; logic [CW-1:0] ic; logic err; logic rdy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic v, logic [TW-1:0] w, logic f, logic b, logic st, logic [TW-1:0] wt,
                              logic fl, logic sb, logic [LW-1:0] lvl, logic [CW-1:0] ic, logic err, logic rdy);
    vec_t r;
    r.v = v; r.w = w; r.f = f; r.b = b; r.st = st; r.wt = wt; r.fl = fl; r.sb = sb;
    r.lvl = lvl; r.ic = ic; r.err = err; r.rdy = rdy;
    return r;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {start, wait_timer, flag, seq_busy, fifo_level, issued_count, err_timeout, cmd_ready};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TW-1:0] w, input logic f);
    logic acc;
    acc = 1'b0;
    tick();
    cmd_valid = 1'b1;
    cmd_wait  = w;
    cmd_flag  = f;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_accept", 0, 1);
  endtask

  task automatic wait_start();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = start;
    end
    if (!got) chk("start_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = !seq_busy;
    end
    if (!got) chk("idle_timeout", 0, 1);
  endtask

  // Counter model: in auto mode goes busy the cycle after start for three cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_mode) begin
        if (cnt_left > 0) begin
          cnt_busy = 1'b1;
          cnt_left--;
        end else begin
          cnt_busy = 1'b0;
        end
        if (start) cnt_left = 3;
      end else begin
        cnt_left = 0;
        cnt_busy = man_busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        n_starts++;
        st_q.push_back(wait_timer);
        if (prev_start) n_b2b++;
      end
      prev_start = start;
      if (err_timeout) n_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, e0, e1, e2, s0, s1, b0, q0, q1, bad;
    logic acc, got;

    // Single command {wait=5, flag=1}, busy during cycles 3..9.
    tbl[0]  = mk(1, 5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0,  1, 5, 1, 1, 0, 0, 0, 1);
    for (int i = 3; i <= 9; i++) tbl[i] = mk(0, 0, 0, 1,  0, 5, 1, 1, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0,  0, 5, 1, 1, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0,  0, 5, 1, 1, 0, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0,  0, 5, 1, 0, 0, 1, 0, 1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", outs(), RST_OUT);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cmd_valid = tbl[i].v;
      cmd_wait  = tbl[i].w;
      cmd_flag  = tbl[i].f;
      man_busy  = tbl[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].st, tbl[i].wt, tbl[i].fl, tbl[i].sb, tbl[i].lvl, tbl[i].ic, tbl[i].err, tbl[i].rdy});
      tick();
    end
    cmd_valid = 1'b0;

    // Busy never arrives: err_timeout exactly ACK_TMO cycles after start, no completion counted.
    e0 = n_err;
    push(9, 0);
    wait_start();
    k = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      k++;
      got = err_timeout;
    end
    chk("tmo_latency", k, ACK_TMO);
    repeat (10) @(negedge clk);
    chk("tmo_pulses", n_err - e0, 1);
    chk("tmo_no_issue", issued_count, 1);
    chk("tmo_back_idle", seq_busy, 0);

    // Busy arrives on the last allowed ack cycle: accepted, no timeout.
    e1 = n_err;
    push(6, 1);
    wait_start();
    repeat (ACK_TMO) tick();
    man_busy = 1'b1;
    @(negedge clk);
    chk("ack_last_cycle", err_timeout, 0);
    tick();
    tick();
    man_busy = 1'b0;
    wait_idle();
    chk("ack_late_issued", issued_count, 2);
    chk("ack_late_no_err", n_err - e1, 0);
    chk("hold_after_run", {wait_timer, flag}, {5'd6, 1'b1});

    // Backpressure: first run held busy, four more fill the FIFO, a sixth waits for a pop.
    s0 = n_starts;
    b0 = n_b2b;
    q0 = st_q.size();
    man_busy = 1'b1;
    push(1, 0);
    push(2, 1);
    push(3, 0);
    push(4, 1);
    push(5, 0);
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b1;
    cmd_wait  = 6;
    cmd_flag  = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready || fifo_level != 4) bad++;
      tick();
    end
    chk("held_while_full", bad, 0);
    auto_mode = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("held_accepted", acc, 1);
    wait_idle();
    chk("fill_starts", n_starts - s0, 6);
    chk("fill_start_gap", n_b2b - b0, 0);
    chk("fill_issued", issued_count, 8);
    for (int i = 0; i < 6; i++) chk($sformatf("fill_order%0d", i), st_q[q0 + i], i + 1);

    // Push and pop in the same cycle at level 2; launch order 9, 3, 7, 0.
    auto_mode = 1'b0;
    man_busy  = 1'b1;
    q1 = st_q.size();
    push(9, 0);
    push(3, 0);
    push(7, 1);
    tick();
    man_busy = 1'b0;
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_wait  = 0;
    cmd_flag  = 1'b0;
    @(negedge clk);
    chk("pp_level_before", fifo_level, 2);
    tick();
    cmd_valid = 1'b0;
    auto_mode = 1'b1;
    @(negedge clk);
    chk("pp_level_after", fifo_level, 2);
    chk("pp_launch_head", {start, wait_timer}, {1'b1, 5'd3});
    wait_idle();
    chk("order_a", st_q[q1],     9);
    chk("order_b", st_q[q1 + 1], 3);
    chk("order_c", st_q[q1 + 2], 7);
    chk("order_d", st_q[q1 + 3], 0);
    chk("order_issued", issued_count, 12);

    // Reset during a run with two commands queued.
    auto_mode = 1'b0;
    man_busy  = 1'b1;
    push(4, 1);
    push(8, 0);
    push(2, 1);
    @(negedge clk);
    chk("pre_reset", {fifo_level, issued_count}, {3'd2, 8'd12});
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_no_err", err_timeout, 0);
    tick();
    rst = 1'b0;
    man_busy = 1'b0;
    @(negedge clk);
    chk("reset_midrun", outs(), RST_OUT);
    s1 = n_starts;
    repeat (10) tick();
    @(negedge clk);
    chk("no_start_after_reset", n_starts - s1, 0);

    // 256 completed runs wrap issued_count back to 0.
    auto_mode = 1'b1;
    e2 = n_err;
    for (int i = 0; i < 255; i++) push(TW'(i), i[0]);
    wait_idle();
    chk("pre_wrap", issued_count, 255);
    push(17, 1);
    wait_idle();
    chk("wrap_to_zero", issued_count, 0);
    chk("wrap_no_err", n_err - e2, 0);
    chk("wrap_idle", {fifo_level, cmd_ready, seq_busy}, {3'd0, 1'b1, 1'b0});
    chk("wrap_last_cmd", {wait_timer, flag}, {5'd17, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
